tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter_pkg.sv | 28 ++
 rtl/tx_arbiter_tag_fifo.sv | 62 ++++++
 rtl/tx_arbiter.sv | 129 ++++++++++++
 tb/tb_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared types for the TX arbiter: outstanding-read tag layout and TX command header codes.
package tx_arbiter_pkg;

    localparam int unsigned TAG_REPLY_W = 1;
    localparam int unsigned TAG_OWNER_W = 1;
    localparam int unsigned TAG_W       = TAG_REPLY_W + TAG_OWNER_W;

    // owner = 1 marks a scheduler transaction, 0 a prefetch (or jump fetch)
    typedef struct packed {
        logic [TAG_REPLY_W-1:0] reply;
        logic [TAG_OWNER_W-1:0] owner;
    } tag_t;

    typedef enum logic [1:0] {
        TX_HEADER_READ_16  = 2'd0,
        TX_HEADER_WRITE_16 = 2'd1,
        TX_HEADER_WRITE_8  = 2'd2,
        TX_HEADER_IDLE     = 2'd3
    } tx_header_e;

    function automatic tag_t make_tag(input logic reply, input logic owner);
        tag_t t;
        t.reply = reply;
        t.owner = owner;
        return t;
    endfunction

endpackage

// File: rtl/tx_arbiter_tag_fifo.sv
// Outstanding-read tag FIFO; pointers wrap modulo DEPTH so any depth >= 2 works.
module tag_fifo
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         add,
    input  logic                         remove,
    input  tag_t                         new_entry,
    output tag_t                         last_entry,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    tag_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign w_push = add & ~full;
    assign w_pop  = remove & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign last_entry = r_mem[r_rd_ptr];
    assign count      = r_count;

endmodule

// File: rtl/tx_arbiter.sv
// TX owner arbiter between scheduler and prefetcher, with outstanding-read tag tracking.
// Build option: TX_ARB_FAIRNESS_EN adds a starvation counter that forces a prefetch grant.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   sc_cmd_valid,
    input  logic                                   sc_reserve,
    input  logic                                   sc_block_pf,
    input  logic                                   sc_reply_wanted,
    input  logic                                   sc_read,
    input  logic                                   pf_cmd_valid,
    input  logic                                   pf_read,
    input  logic                                   write_pc,
    input  logic                                   tx_command_started,
    input  logic                                   tx_active,
    input  logic                                   rx_done,
    output logic                                   sc_tx,
    output logic                                   pf_tx,
    output logic                                   tx_command_valid,
    output logic                                   tx_fetch,
    output logic                                   tx_jump,
    output logic                                   prefetch_idle,
    output logic                                   sc_rx,
    output logic                                   pf_rx,
    output logic                                   full,
    output logic                                   empty,
    output logic                                   proto_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    if (MAX_OUTSTANDING < 2 || STARVE_LIMIT == 0) begin : g_bad_params
        $error("tx_arbiter: MAX_OUTSTANDING must be >= 2 and STARVE_LIMIT >= 1");
    end

    logic   r_curr_sc;
    logic   r_proto_err;
    logic   w_sc_wanted;
    logic   w_grant_sc;
    logic   w_owner_valid;
    logic   w_sel_read;
    logic   w_push;
    logic   w_full;
    logic   w_empty;
    tag_t   w_new_tag;
    tag_t   w_head;

    assign w_sc_wanted = sc_cmd_valid | sc_reserve | sc_block_pf;

`ifdef TX_ARB_FAIRNESS_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT+1);

    logic [STARVE_W-1:0] r_starve;
    logic                w_force_pf;

    // A reserved or prefetch-blocked scheduler is never overridden; the counter waits at the limit.
    assign w_force_pf = (r_starve == STARVE_W'(STARVE_LIMIT)) & ~sc_reserve & ~sc_block_pf;
    assign w_grant_sc = w_sc_wanted & ~w_force_pf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (!tx_active) begin
            if (!w_grant_sc || !pf_cmd_valid) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_W'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    assign w_grant_sc = w_sc_wanted;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_curr_sc <= 1'b0;
        end else if (!tx_active) begin
            r_curr_sc <= w_grant_sc;
        end
    end

    assign sc_tx         = tx_active ? r_curr_sc : w_grant_sc;
    assign pf_tx         = ~sc_tx;
    assign prefetch_idle = tx_active ? r_curr_sc : sc_block_pf;
    assign tx_fetch      = pf_tx | write_pc;
    assign tx_jump       = write_pc;

    assign w_owner_valid    = sc_tx ? sc_cmd_valid : pf_cmd_valid;
    assign w_sel_read       = sc_tx ? sc_read : pf_read;
    assign tx_command_valid = w_owner_valid & ~(w_full & w_sel_read);

    // Jump fetches reply into the prefetcher, so they are tagged as prefetch-owned.
    assign w_push    = tx_command_started & w_sel_read;
    assign w_new_tag = make_tag(sc_tx ? sc_reply_wanted : 1'b1, sc_tx & ~write_pc);

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .add        (w_push),
        .remove     (rx_done),
        .new_entry  (w_new_tag),
        .last_entry (w_head),
        .empty      (w_empty),
        .full       (w_full),
        .count      (outstanding)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_proto_err <= 1'b0;
        end else if ((rx_done & w_empty) | (w_push & w_full)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign sc_rx     = ~w_empty & w_head.reply & w_head.owner;
    assign pf_rx     = ~w_empty & w_head.reply & ~w_head.owner;
    assign full      = w_full;
    assign empty     = w_empty;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: idle-grant vector table, directed multi-cycle sequences, randomized run vs. a queue model.
module tb_tx_arbiter;

    localparam int unsigned MAXO  = 4;
    localparam int unsigned LIMIT = 4;

    logic clk;
    logic reset;
    logic sc_cmd_valid, sc_reserve, sc_block_pf, sc_reply_wanted, sc_read;
    logic pf_cmd_valid, pf_read, write_pc;
    logic tx_command_started, tx_active, rx_done;
    logic sc_tx, pf_tx, tx_command_valid, tx_fetch, tx_jump, prefetch_idle;
    logic sc_rx, pf_rx, full, empty, proto_err;
    logic [2:0] outstanding;

    int checks   = 0;
    int failures = 0;

    tx_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sc_cmd_valid       (sc_cmd_valid),
        .sc_reserve         (sc_reserve),
        .sc_block_pf        (sc_block_pf),
        .sc_reply_wanted    (sc_reply_wanted),
        .sc_read            (sc_read),
        .pf_cmd_valid       (pf_cmd_valid),
        .pf_read            (pf_read),
        .write_pc           (write_pc),
        .tx_command_started (tx_command_started),
        .tx_active          (tx_active),
        .rx_done            (rx_done),
        .sc_tx              (sc_tx),
        .pf_tx              (pf_tx),
        .tx_command_valid   (tx_command_valid),
        .tx_fetch           (tx_fetch),
        .tx_jump            (tx_jump),
        .prefetch_idle      (prefetch_idle),
        .sc_rx              (sc_rx),
        .pf_rx              (pf_rx),
        .full               (full),
        .empty              (empty),
        .proto_err          (proto_err),
        .outstanding        (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive_idle();
        sc_cmd_valid = 0; sc_reserve = 0; sc_block_pf = 0; sc_reply_wanted = 0; sc_read = 0;
        pf_cmd_valid = 0; pf_read = 0; write_pc = 0;
        tx_command_started = 0; tx_active = 0; rx_done = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // idle-arbitration vectors: exp = {sc_tx, prefetch_idle, tx_fetch, tx_jump, tx_command_valid}
    typedef struct {
        logic scv, res, blk, rd, pfv, pfrd, wpc;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[9];

    // behavioural model state
    bit   m_curr;
    bit   m_err;
    int   m_starve;
    bit [1:0] m_q[$];

    initial begin
        // reset state
        drive_idle();
        reset = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_sc_rx", sc_rx, 0);
        chk("rst_pf_rx", pf_rx, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_pf_tx", pf_tx, 1);
        chk("rst_proto_err", proto_err, 0);
        cyc();
        reset = 1'b1;

        vecs[0] = '{0,0,0,0,0,0,0, 5'b00100};
        vecs[1] = '{1,0,0,0,1,0,0, 5'b10001};
        vecs[2] = '{0,0,0,0,1,1,0, 5'b00101};
        vecs[3] = '{0,1,0,0,1,0,0, 5'b10000};
        vecs[4] = '{0,0,1,0,0,0,0, 5'b11000};
        vecs[5] = '{1,0,0,1,0,0,1, 5'b10111};
        vecs[6] = '{0,0,1,0,1,0,0, 5'b11000};
        vecs[7] = '{1,1,1,0,0,0,0, 5'b11001};
        vecs[8] = '{0,0,0,0,1,0,1, 5'b00111};
        for (int i = 0; i < 9; i++) begin
            cyc();
            drive_idle();
            sc_cmd_valid = vecs[i].scv; sc_reserve = vecs[i].res; sc_block_pf = vecs[i].blk;
            sc_read = vecs[i].rd; pf_cmd_valid = vecs[i].pfv; pf_read = vecs[i].pfrd;
            write_pc = vecs[i].wpc;
            #1;
            chk($sformatf("vec%0d", i), {sc_tx, prefetch_idle, tx_fetch, tx_jump, tx_command_valid}, vecs[i].exp);
            chk($sformatf("vec%0d_pf_tx", i), pf_tx, {31'd0, ~vecs[i].exp[4]});
        end

        // owner held across tx_active
        do_reset();
        pf_cmd_valid = 1;
        #1 chk("idle_pf_grant", sc_tx, 0);
        cyc();
        tx_active = 1; sc_cmd_valid = 1;
        #1 chk("midtx_owner_held", sc_tx, 0);
        chk("midtx_prefetch_idle", prefetch_idle, 0);
        cyc();
        #1 chk("midtx_owner_held2", sc_tx, 0);
        cyc();
        tx_active = 0;
        #1 chk("tx_end_regrant", sc_tx, 1);
        cyc();
        tx_active = 1; sc_cmd_valid = 0;
        #1 chk("midtx_sc_held", sc_tx, 1);
        chk("midtx_sc_prefetch_idle", prefetch_idle, 1);

        // fill with prefetch reads
        do_reset();
        pf_cmd_valid = 1; pf_read = 1; tx_command_started = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("pf_read_valid", tx_command_valid, 1);
            chk("fill_count", outstanding, i);
            cyc();
        end
        tx_command_started = 0;
        #1 chk("full_flag", full, 1);
        chk("full_count", outstanding, 4);
        chk("fifth_read_blocked", tx_command_valid, 0);
        pf_read = 0;
        #1 chk("nonread_when_full", tx_command_valid, 1);
        chk("full_head_pf_rx", pf_rx, 1);
        chk("full_head_sc_rx", sc_rx, 0);
        pf_read = 1; tx_command_started = 1;
        cyc();
        tx_command_started = 0;
        #1 chk("push_full_count", outstanding, 4);
        chk("push_full_err", proto_err, 1);
        do_reset();
        #1 chk("midtx_reset_count", outstanding, 0);
        chk("midtx_reset_empty", empty, 1);
        chk("midtx_reset_err", proto_err, 0);

        // jump fetch then plain scheduler read
        sc_cmd_valid = 1; sc_read = 1; write_pc = 1; sc_reply_wanted = 1; tx_command_started = 1;
        #1 chk("jump_fetch", {tx_fetch, tx_jump}, 2'b11);
        cyc();
        write_pc = 0;
        #1 chk("jump_tag_pf", pf_rx, 1);
        cyc();
        drive_idle();
        rx_done = 1;
        #1 chk("two_outstanding", outstanding, 2);
        chk("head_pf_rx", pf_rx, 1);
        cyc();
        #1 chk("second_tag_sc", {sc_rx, pf_rx}, 2'b10);
        cyc();
        rx_done = 0;
        #1 chk("drained_empty", empty, 1);
        chk("drained_rx", {sc_rx, pf_rx}, 2'b00);
        chk("drained_err", proto_err, 0);
        sc_cmd_valid = 1; sc_read = 1; sc_reply_wanted = 0; tx_command_started = 1;
        cyc();
        drive_idle();
        #1 chk("no_reply_count", outstanding, 1);
        chk("no_reply_rx", {sc_rx, pf_rx}, 2'b00);

        // simultaneous push and pop with one entry
        do_reset();
        pf_cmd_valid = 1; pf_read = 1; tx_command_started = 1;
        cyc();
        drive_idle();
        sc_cmd_valid = 1; sc_read = 1; sc_reply_wanted = 1; tx_command_started = 1; rx_done = 1;
        #1 chk("pre_simul_head", pf_rx, 1);
        cyc();
        drive_idle();
        #1 chk("simul_count", outstanding, 1);
        chk("simul_head", {sc_rx, pf_rx}, 2'b10);
        chk("simul_err", proto_err, 0);

        // pop while empty
        do_reset();
        rx_done = 1;
        cyc();
        rx_done = 0;
        #1 chk("underflow_err", proto_err, 1);
        chk("underflow_count", outstanding, 0);
        chk("underflow_empty", empty, 1);
        pf_cmd_valid = 1; pf_read = 1; tx_command_started = 1;
        cyc();
        drive_idle();
        repeat (2) cyc();
        #1 chk("err_sticky", proto_err, 1);
        chk("err_sticky_count", outstanding, 1);
        #2 reset = 1'b0;
        #1 chk("err_async_clear", proto_err, 0);
        chk("async_clear_count", outstanding, 0);
        cyc();
        reset = 1'b1;

`ifdef TX_ARB_FAIRNESS_EN
        do_reset();
        sc_cmd_valid = 1; pf_cmd_valid = 1;
        for (int k = 1; k <= 6; k++) begin
            #1 chk($sformatf("fair_arb%0d", k), sc_tx, (k == 5) ? 0 : 1);
            cyc();
        end
`endif

        // randomized run against the queue model
        for (int chunk = 0; chunk < 10; chunk++) begin
            do_reset();
            m_curr = 0; m_err = 0; m_starve = 0; m_q.delete();
            for (int n = 0; n < 200; n++) begin
                bit want, gsc, e_sc, rdsel, vsel, e_full, e_valid, e_scrx, e_pfrx, push, pop;
                bit [13:0] e_vec;
                int pre;
                drive_idle();
                tx_active       = ($urandom_range(0, 2) == 0);
                sc_cmd_valid    = $urandom_range(0, 1);
                sc_reserve      = ($urandom_range(0, 7) == 0);
                sc_block_pf     = ($urandom_range(0, 7) == 0);
                sc_read         = $urandom_range(0, 1);
                sc_reply_wanted = $urandom_range(0, 1);
                pf_cmd_valid    = $urandom_range(0, 1);
                pf_read         = $urandom_range(0, 1);
                write_pc        = ($urandom_range(0, 3) == 0);

                want = sc_cmd_valid | sc_reserve | sc_block_pf;
                gsc  = want;
`ifdef TX_ARB_FAIRNESS_EN
                if (m_starve >= LIMIT && !sc_reserve && !sc_block_pf) gsc = 0;
`endif
                e_sc    = tx_active ? m_curr : gsc;
                rdsel   = e_sc ? sc_read : pf_read;
                vsel    = e_sc ? sc_cmd_valid : pf_cmd_valid;
                e_full  = (m_q.size() == MAXO);
                e_valid = vsel && !(e_full && rdsel);
                e_scrx  = (m_q.size() > 0) && m_q[0][1] && m_q[0][0];
                e_pfrx  = (m_q.size() > 0) && m_q[0][1] && !m_q[0][0];
                e_vec = {e_sc, !e_sc, e_valid, (!e_sc) | write_pc, write_pc,
                         tx_active ? m_curr : sc_block_pf, e_scrx, e_pfrx, e_full,
                         (m_q.size() == 0), m_err, 3'(m_q.size())};

                tx_command_started = e_valid ? $urandom_range(0, 1) : ($urandom_range(0, 49) == 0);
                rx_done = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
                #1;
                chk($sformatf("random c%0d n%0d", chunk, n),
                    {sc_tx, pf_tx, tx_command_valid, tx_fetch, tx_jump, prefetch_idle,
                     sc_rx, pf_rx, full, empty, proto_err, outstanding}, e_vec);

                if (!tx_active) begin
`ifdef TX_ARB_FAIRNESS_EN
                    if (!gsc || !pf_cmd_valid) m_starve = 0;
                    else if (m_starve < LIMIT) m_starve++;
`endif
                    m_curr = gsc;
                end
                push = tx_command_started && rdsel;
                pop  = rx_done;
                pre  = m_q.size();
                if (pop) begin
                    if (pre > 0) void'(m_q.pop_front());
                    else m_err = 1;
                end
                if (push) begin
                    if (pre < MAXO) m_q.push_back({e_sc ? sc_reply_wanted : 1'b1, e_sc && !write_pc});
                    else m_err = 1;
                end
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
